// File: rtl/gpi_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : gpi_conditioner
// Purpose  : Synchronise, debounce and edge-detect raw board pins; sticky
//            software-clearable rise/fall flags with a level interrupt.
// Revision : 1.0  initial release
// ============================================================================
module gpi_conditioner #(
  parameter int WIDTH    = 32,
  parameter int TICK_DIV = 1000,
  parameter int STABLE_N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin_in,
  input  logic             clr_we,
  input  logic [WIDTH-1:0] clr_mask,
  output logic [WIDTH-1:0] gpi_q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             irq
);

  localparam int                 c_CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(TICK_DIV - 1);

  logic [WIDTH-1:0]                r_s1;
  logic [WIDTH-1:0]                r_s2;
  logic [c_CNT_W-1:0]              r_cnt;
  logic [WIDTH-1:0][STABLE_N-2:0]  r_hist;
  logic [WIDTH-1:0]                r_q;
  logic [WIDTH-1:0]                r_rise;
  logic [WIDTH-1:0]                r_fall;

  logic                            w_tick;
  logic [WIDTH-1:0][STABLE_N-1:0]  w_nh;
  logic [WIDTH-1:0]                w_all1;
  logic [WIDTH-1:0]                w_all0;
  logic [WIDTH-1:0]                w_set_rise;
  logic [WIDTH-1:0]                w_set_fall;
  logic [WIDTH-1:0]                w_clr;

  // Two-flop synchroniser; only r_s2 is safe to use downstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= pin_in;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_CNT_W'(1);
    end
  end

  assign w_tick = (r_cnt == c_CNT_MAX);

  // Candidate history includes the current sample, so a level is accepted on
  // the same tick that completes STABLE_N equal samples.
  always_comb begin
    w_nh   = '0;
    w_all1 = '0;
    w_all0 = '0;
    for (int b = 0; b < WIDTH; b++) begin
      w_nh[b]   = {r_hist[b], r_s2[b]};
      w_all1[b] = &w_nh[b];
      w_all0[b] = ~|w_nh[b];
    end
  end

  assign w_set_rise = {WIDTH{w_tick}} & w_all1 & ~r_q;
  assign w_set_fall = {WIDTH{w_tick}} & w_all0 &  r_q;
  assign w_clr      = {WIDTH{clr_we}} & clr_mask;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist <= '0;
    end else if (w_tick) begin
      for (int b = 0; b < WIDTH; b++) begin
        r_hist[b] <= w_nh[b][STABLE_N-2:0];
      end
    end
  end

  // A new event on the same edge as a clear takes priority over the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q    <= '0;
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_q    <= (r_q | w_set_rise) & ~w_set_fall;
      r_rise <= w_set_rise | (r_rise & ~w_clr);
      r_fall <= w_set_fall | (r_fall & ~w_clr);
    end
  end

  assign gpi_q = r_q;
  assign rise  = r_rise;
  assign fall  = r_fall;
  assign irq   = |(r_rise | r_fall);

endmodule
`default_nettype wire

// File: tb/tb_gpi_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpi_conditioner
// Purpose  : Self-checking bench for gpi_conditioner (TICK_DIV=1 and 10).
// Revision : 1.0  initial release
// ============================================================================
module tb_gpi_conditioner;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pin_a, pin_b, clr_mask_a, clr_mask_b;
  logic        clr_we_a, clr_we_b;
  logic [31:0] gq_a, rise_a, fall_a, gq_b, rise_b, fall_b;
  logic        irq_a, irq_b;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  gpi_conditioner #(.WIDTH(32), .TICK_DIV(1), .STABLE_N(4)) u_dut_a (
    .clk(clk), .rst(rst), .pin_in(pin_a), .clr_we(clr_we_a), .clr_mask(clr_mask_a),
    .gpi_q(gq_a), .rise(rise_a), .fall(fall_a), .irq(irq_a)
  );

  gpi_conditioner #(.WIDTH(32), .TICK_DIV(10), .STABLE_N(4)) u_dut_b (
    .clk(clk), .rst(rst), .pin_in(pin_b), .clr_we(clr_we_b), .clr_mask(clr_mask_b),
    .gpi_q(gq_b), .rise(rise_b), .fall(fall_b), .irq(irq_b)
  );

  // Reference model: two-stage delay, then run-length counting of equal samples.
  logic [31:0] m_s1 [2];
  logic [31:0] m_s2 [2];
  logic [31:0] m_last [2];
  logic [31:0] m_q [2];
  logic [31:0] m_rise [2];
  logic [31:0] m_fall [2];
  int          m_run [2][32];
  int          m_n [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_s1[d] = '0; m_s2[d] = '0; m_last[d] = '0;
      m_q[d] = '0; m_rise[d] = '0; m_fall[d] = '0; m_n[d] = 0;
      for (int b = 0; b < 32; b++) m_run[d][b] = 0;
    end
  endtask

  task automatic model_edge(input int d, input logic [31:0] pin, input logic cwe,
                            input logic [31:0] cm);
    int          t;
    bit          tick;
    logic [31:0] sr, sf, clr;
    t    = (d == 0) ? 1 : 10;
    tick = ((m_n[d] % t) == t - 1);
    m_n[d]++;
    sr = '0; sf = '0;
    if (tick) begin
      for (int b = 0; b < 32; b++) begin
        if (m_s2[d][b] == m_last[d][b]) begin
          if (m_run[d][b] < 1000) m_run[d][b]++;
        end else begin
          m_run[d][b] = 1;
          m_last[d][b] = m_s2[d][b];
        end
        if (m_run[d][b] >= 4 && m_q[d][b] != m_last[d][b]) begin
          if (m_last[d][b]) sr[b] = 1'b1; else sf[b] = 1'b1;
          m_q[d][b] = m_last[d][b];
        end
      end
    end
    clr = cwe ? cm : 32'h0;
    m_rise[d] = sr | (m_rise[d] & ~clr);
    m_fall[d] = sf | (m_fall[d] & ~clr);
    m_s2[d] = m_s1[d];
    m_s1[d] = pin;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("a_q",    gq_a,   m_q[0]);
    chk("a_rise", rise_a, m_rise[0]);
    chk("a_fall", fall_a, m_fall[0]);
    chk("a_irq",  {31'b0, irq_a}, {31'b0, |(m_rise[0] | m_fall[0])});
    chk("b_q",    gq_b,   m_q[1]);
    chk("b_rise", rise_b, m_rise[1]);
    chk("b_fall", fall_b, m_fall[1]);
    chk("b_irq",  {31'b0, irq_b}, {31'b0, |(m_rise[1] | m_fall[1])});
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) begin
      model_edge(0, pin_a, clr_we_a, clr_mask_a);
      model_edge(1, pin_b, clr_we_b, clr_mask_b);
    end else begin
      model_reset();
    end
    #1;
    check_all();
  endtask

  task automatic clear_all_a();
    clr_we_a = 1'b1; clr_mask_a = '1;
    step();
    clr_we_a = 1'b0; clr_mask_a = '0;
  endtask

  initial begin
    int  hi;
    int  lat;
    bit  seen;
    rst = 1'b0; pin_a = '1; pin_b = '0;
    clr_we_a = 1'b0; clr_mask_a = '0; clr_we_b = 1'b0; clr_mask_b = '0;
    model_reset();
    #2;
    chk("rst_q",    gq_a,   32'h0);
    chk("rst_rise", rise_a, 32'h0);
    chk("rst_irq",  {31'b0, irq_a}, 32'h0);
    step();
    rst = 1'b1;

    // Pins high through reset: rise on the 6th edge after release
    repeat (5) step();
    chk("t1_q_edge5", gq_a, 32'h0);
    step();
    chk("t1_q_edge6", gq_a,   32'hFFFF_FFFF);
    chk("t1_rise",    rise_a, 32'hFFFF_FFFF);
    chk("t1_fall",    fall_a, 32'h0);
    chk("t1_irq",     {31'b0, irq_a}, 32'h1);

    pin_a = '0;
    repeat (8) step();
    clear_all_a();
    chk("clr_all", rise_a | fall_a, 32'h0);

    // Glitch of 3 samples is rejected; 4 samples gives a 4-cycle pulse
    pin_a = 32'h1; hi = 0;
    repeat (3) begin step(); hi += int'(gq_a[0]); end
    pin_a = 32'h0;
    repeat (8) begin step(); hi += int'(gq_a[0]); end
    chk("glitch_hi",   hi, 0);
    chk("glitch_rise", rise_a, 32'h0);
    pin_a = 32'h1; hi = 0;
    repeat (4) begin step(); hi += int'(gq_a[0]); end
    pin_a = 32'h0;
    repeat (10) begin step(); hi += int'(gq_a[0]); end
    chk("pulse_len",  hi, 4);
    chk("pulse_rise", rise_a, 32'h1);
    chk("pulse_fall", fall_a, 32'h1);
    clear_all_a();

    // Clear of a single flag, then clear coinciding with a new rise
    pin_a = 32'h20;
    repeat (6) step();
    chk("t4_rise", rise_a, 32'h20);
    clr_we_a = 1'b1; clr_mask_a = 32'h20;
    step();
    clr_we_a = 1'b0; clr_mask_a = '0;
    chk("t4_rise_clr", rise_a, 32'h0);
    chk("t4_irq_clr",  {31'b0, irq_a}, 32'h0);
    pin_a = 32'h0;
    repeat (10) step();
    clear_all_a();
    pin_a = 32'h20;
    repeat (5) step();
    chk("t4_pre_q", {31'b0, gq_a[5]}, 32'h0);
    clr_we_a = 1'b1; clr_mask_a = 32'h20;
    step();
    clr_we_a = 1'b0; clr_mask_a = '0;
    chk("t4_set_wins", {31'b0, rise_a[5]}, 32'h1);

    // Falling bit 7 leaves its rise flag alone
    pin_a = 32'hA0;
    repeat (6) step();
    chk("t5_q_hi", {31'b0, gq_a[7]}, 32'h1);
    pin_a = 32'h20;
    repeat (6) step();
    chk("t5_fall", {31'b0, fall_a[7]}, 32'h1);
    chk("t5_rise", {31'b0, rise_a[7]}, 32'h1);
    chk("t5_q_lo", {31'b0, gq_a[7]}, 32'h0);

    // Reset in the middle of debouncing bit 2
    pin_a = 32'h24;
    repeat (4) step();
    rst = 1'b0;
    model_reset();
    #1;
    chk("t6_q",    gq_a,   32'h0);
    chk("t6_rise", rise_a, 32'h0);
    chk("t6_fall", fall_a, 32'h0);
    chk("t6_irq",  {31'b0, irq_a}, 32'h0);
    step();
    rst = 1'b1;
    repeat (5) step();
    chk("t6_q2_edge5", {31'b0, gq_a[2]}, 32'h0);
    step();
    chk("t6_q2_edge6", {31'b0, gq_a[2]}, 32'h1);

    // TICK_DIV=10 latency window on bit 3
    repeat (2) begin
      repeat ($urandom_range(0, 9)) step();
      pin_b[3] = 1'b1; seen = 0; lat = -1;
      for (int j = 1; j <= 60; j++) begin
        step();
        if (!seen && gq_b[3]) begin seen = 1; lat = j - 1; end
      end
      chk("t3_latency_in_window", 32'(lat >= 32 && lat <= 41), 32'h1);
      pin_b[3] = 1'b0;
      repeat (50) step();
    end

    // Randomised phase against the model
    repeat (400) begin
      if ($urandom_range(0, 3) == 0)  pin_a = pin_a ^ ($urandom & $urandom & $urandom);
      if ($urandom_range(0, 15) == 0) pin_b = pin_b ^ ($urandom & $urandom);
      clr_we_a = ($urandom_range(0, 5) == 0); clr_mask_a = $urandom;
      clr_we_b = ($urandom_range(0, 5) == 0); clr_mask_b = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
